// File: rtl/dec_key_arbiter.sv
// rtl/dec_key_arbiter.sv - debounced 10-key decimal keypad to BCD arbiter with valid/ready handoff
module dec_key_arbiter #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] keys,
    input  logic       bcd_ready,
    output logic [3:0] bcd,
    output logic       bcd_valid,
    output logic       err,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        OUTPUT       = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    // The snapshot in IDLE is the first matching sample, so a press needs
    // DEBOUNCE_CYCLES-1 further matches; a release needs DEBOUNCE_CYCLES zeros.
    localparam logic [15:0] CNT_ACCEPT  = 16'(DEBOUNCE_CYCLES - 2);
    localparam logic [15:0] CNT_RELEASE = 16'(DEBOUNCE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [9:0]  sync_q;
    logic [9:0]  keys_s_q;
    logic [9:0]  key_q, key_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bcd_q, bcd_d;
    logic        err_q, err_d;
    logic [7:0]  press_cnt_q, press_cnt_d;

    logic        key_onehot;
    logic [3:0]  key_idx;

    assign key_onehot = (key_q != 10'd0) && ((key_q & (key_q - 10'd1)) == 10'd0);

    always_comb begin
        key_idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key_q[i]) begin
                key_idx = 4'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        err_d       = 1'b0;
        press_cnt_d = press_cnt_q;

        case (state_q)
            IDLE: begin
                if (keys_s_q != 10'd0) begin
                    key_d   = keys_s_q;
                    cnt_d   = 16'd0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (keys_s_q != key_q) begin
                    cnt_d = 16'd0;
                    if (keys_s_q == 10'd0) begin
                        state_d = IDLE;
                    end else begin
                        key_d = keys_s_q;
                    end
                end else if (cnt_q == CNT_ACCEPT) begin
                    cnt_d = 16'd0;
                    if (key_onehot) begin
                        bcd_d   = key_idx;
                        state_d = OUTPUT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            OUTPUT: begin
                if (bcd_ready) begin
                    press_cnt_d = press_cnt_q + 8'd1;
                    cnt_d       = 16'd0;
                    state_d     = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (keys_s_q != 10'd0) begin
                    cnt_d = 16'd0;
                end else if (cnt_q == CNT_RELEASE) begin
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync_q      <= 10'd0;
            keys_s_q    <= 10'd0;
            key_q       <= 10'd0;
            cnt_q       <= 16'd0;
            bcd_q       <= 4'd0;
            err_q       <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            sync_q      <= keys;
            keys_s_q    <= sync_q;
            key_q       <= key_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            err_q       <= err_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = (state_q == OUTPUT);
    assign err       = err_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_dec_key_arbiter.sv
// tb/tb_dec_key_arbiter.sv - directed vector bench for dec_key_arbiter
module tb_dec_key_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] keys;
    logic       bcd_ready;
    logic [3:0] bcd;
    logic       bcd_valid;
    logic       err;
    logic [7:0] press_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int exp_pc;

    dec_key_arbiter #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .keys      (keys),
        .bcd_ready (bcd_ready),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .err       (err),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [9:0] keys;
        logic       rdy;
        logic       v;
        logic       e;
        logic [3:0] b;
        logic [7:0] c;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int n, input logic r, input logic [9:0] k, input logic rd,
                                input logic v, input logic e, input logic [3:0] b, input logic [7:0] c);
        vec_t x;
        x.rst = r; x.keys = k; x.rdy = rd; x.v = v; x.e = e; x.b = b; x.c = c;
        repeat (n) tbl.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [9:0] k, input logic rd);
        rst = r; keys = k; bcd_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic release_keys();
        repeat (7) step(1'b0, 10'd0, 1'b1);
    endtask

    // Drive a key with the given ready level until bcd_valid rises; returns edges taken.
    task automatic wait_valid(input logic [9:0] k, input logic rd, output int lat);
        lat = 0;
        do begin
            step(1'b0, k, rd);
            lat++;
        end while (!bcd_valid && lat < 20);
    endtask

    initial begin
        int  lat;
        int  pulses;
        int  bad_bcd;
        logic seen;
        logic [3:0] got_bcd;

        rst = 1'b1; keys = 10'd0; bcd_ready = 1'b0;

        // Each row is one rising edge; expectations are checked 1 time unit after it.
        add(2, 1, 10'h000, 0, 0, 0, 4'd0, 8'd0);
        add(5, 0, 10'h008, 1, 0, 0, 4'd0, 8'd0);
        add(1, 0, 10'h008, 1, 1, 0, 4'd3, 8'd0);
        add(4, 0, 10'h008, 1, 0, 0, 4'd3, 8'd1);
        add(2, 0, 10'h000, 1, 0, 0, 4'd3, 8'd1);
        add(9, 0, 10'h008, 1, 0, 0, 4'd3, 8'd1);
        add(6, 0, 10'h000, 1, 0, 0, 4'd3, 8'd1);
        add(5, 0, 10'h008, 1, 0, 0, 4'd3, 8'd1);
        add(1, 0, 10'h008, 1, 1, 0, 4'd3, 8'd1);
        add(1, 0, 10'h008, 1, 0, 0, 4'd3, 8'd2);
        add(6, 0, 10'h000, 1, 0, 0, 4'd3, 8'd2);
        add(5, 0, 10'h024, 1, 0, 0, 4'd3, 8'd2);
        add(1, 0, 10'h024, 1, 0, 1, 4'd3, 8'd2);
        add(4, 0, 10'h024, 1, 0, 0, 4'd3, 8'd2);
        add(6, 0, 10'h000, 1, 0, 0, 4'd3, 8'd2);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].keys, tbl[i].rdy);
            chk($sformatf("tbl[%0d] {valid,err,bcd,press_cnt}", i),
                {18'd0, bcd_valid, err, bcd, press_cnt},
                {18'd0, tbl[i].v, tbl[i].e, tbl[i].b, tbl[i].c});
        end
        exp_pc = 2;

        // Bouncing key 4 never settles long enough, then key 9 settles.
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, ((i / 2) % 2 == 0) ? 10'h010 : 10'h000, 1'b1);
            if (bcd_valid) seen = 1'b1;
        end
        chk("bounce_no_accept", {31'd0, seen}, 32'd0);
        pulses = 0; got_bcd = 4'hf;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 10'h200, 1'b1);
            if (bcd_valid) begin
                pulses++;
                got_bcd = bcd;
            end
        end
        exp_pc++;
        chk("bounce_one_digit", pulses, 1);
        chk("bounce_bcd", {28'd0, got_bcd}, 32'd9);
        chk("bounce_press_cnt", {24'd0, press_cnt}, exp_pc);
        release_keys();

        // Key 0 held with no ready: digit waits, then drops right after the handshake.
        wait_valid(10'h001, 1'b0, lat);
        chk("key0_latency", lat, 6);
        chk("key0_bcd", {28'd0, bcd}, 32'd0);
        seen = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 10'h001, 1'b0);
            if (!(bcd_valid && bcd == 4'd0)) seen = 1'b0;
        end
        chk("key0_hold", {31'd0, seen}, 32'd1);
        chk("key0_cnt_before", {24'd0, press_cnt}, exp_pc);
        step(1'b0, 10'h001, 1'b1);
        exp_pc++;
        chk("key0_valid_drop", {31'd0, bcd_valid}, 32'd0);
        chk("key0_press_cnt", {24'd0, press_cnt}, exp_pc);
        release_keys();

        // Reset while key 7 is presented discards it; the held key is pressed anew.
        wait_valid(10'h080, 1'b0, lat);
        chk("rst_pre_bcd", {27'd0, bcd_valid, bcd}, 32'h17);
        step(1'b1, 10'h080, 1'b0);
        chk("rst_outputs", {18'd0, bcd_valid, err, bcd, press_cnt}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 10'h080, 1'b0);
            if (bcd_valid) seen = 1'b1;
        end
        chk("rst_no_early_valid", {31'd0, seen}, 32'd0);
        step(1'b0, 10'h080, 1'b0);
        chk("rst_represent", {19'd0, bcd_valid, bcd, press_cnt}, {19'd0, 1'b1, 4'd7, 8'd0});
        step(1'b0, 10'h080, 1'b1);
        chk("rst_handshake_cnt", {24'd0, press_cnt}, 32'd1);
        release_keys();

        // 256 presses of key 1 wrap the counter.
        step(1'b1, 10'd0, 1'b0);
        bad_bcd = 0;
        for (int p = 1; p <= 256; p++) begin
            wait_valid(10'h002, 1'b1, lat);
            if (lat != 6 || bcd != 4'd1) bad_bcd++;
            step(1'b0, 10'h002, 1'b1);
            if (p == 255) chk("wrap_cnt_255", {24'd0, press_cnt}, 32'd255);
            release_keys();
        end
        chk("wrap_bcd_latency", bad_bcd, 0);
        chk("wrap_cnt_0", {24'd0, press_cnt}, 32'd0);
        chk("wrap_idle", {30'd0, bcd_valid, err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dec_key_arbiter.md
DEC_KEY_ARBITER -- requirements
Module: dec_key_arbiter

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 4, meaning consecutive identical synchronized samples required to accept a press or a release (legal range 2..65535).
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL provide port keys  input  10  raw decimal key lines, active-high, bit i = digit i, asynchronous to clk.
REQ-005 SHALL provide port bcd_ready  input  1  consumer accepts the presented digit when high together with bcd_valid.
REQ-006 SHALL provide port bcd  output  4  BCD code of the accepted key.
REQ-007 SHALL provide port bcd_valid  output  1  bcd holds an accepted digit awaiting handshake.
REQ-008 SHALL provide port err  output  1  one-cycle pulse when a stable multi-key press is rejected.
REQ-009 SHALL provide port press_cnt  output  8  count of digits handed off through the handshake.

Function
REQ-010 SHALL pass keys through a 2-flop synchronizer; keys_s is the second stage, and all decisions use keys_s only.
REQ-011 SHALL implement an FSM with states IDLE, DEBOUNCE, OUTPUT, WAIT_RELEASE.
REQ-012 IDLE: keys_s==0 -> stay; keys_s!=0 -> snapshot key_q<=keys_s, cnt<=0, go DEBOUNCE.
REQ-013 DEBOUNCE: keys_s!=key_q and keys_s==0 -> IDLE.
REQ-014 DEBOUNCE: keys_s!=key_q and keys_s!=0 -> key_q<=keys_s, cnt<=0, stay (restart).
REQ-015 DEBOUNCE: keys_s==key_q and cnt<DEBOUNCE_CYCLES-2 -> cnt++.
REQ-016 DEBOUNCE: keys_s==key_q and cnt==DEBOUNCE_CYCLES-2 -> press accepted; one-hot key_q -> bcd<=index, go OUTPUT; otherwise err pulse for 1 cycle, go WAIT_RELEASE.
REQ-017 Encoding: bit i of key_q -> bcd=i (i=0..9); key 0 yields bcd=4'd0 with bcd_valid=1.
REQ-018 OUTPUT: bcd_valid=1, bcd stable; bcd_valid&bcd_ready -> press_cnt++ (wrap 255->0), cnt<=0, go WAIT_RELEASE; bcd_ready=0 -> hold indefinitely regardless of keys.
REQ-019 bcd_valid SHALL be high only in OUTPUT and SHALL never drop without a handshake except on rst.
REQ-020 WAIT_RELEASE: keys_s!=0 -> cnt<=0; keys_s==0 -> cnt++; on the DEBOUNCE_CYCLES-th consecutive zero sample -> IDLE; no new press is accepted before release completes.
REQ-021 Latency: a clean key applied before edge 0 with bcd_ready low SHALL show bcd_valid=1 after edge DEBOUNCE_CYCLES+1 (6th edge for default).
REQ-022 bcd SHALL retain the last accepted digit outside OUTPUT; err SHALL be 0 except the single rejection cycle.
REQ-023 cnt SHALL be 16 bits wide and never exceed DEBOUNCE_CYCLES-1.

Reset
REQ-024 rst high at a rising edge SHALL force state=IDLE, synchronizer=0, key_q=0, cnt=0, bcd=0, bcd_valid=0, err=0, press_cnt=0, overriding all other inputs.
REQ-025 rst asserted mid-operation (any state, including OUTPUT without handshake) SHALL discard the pending digit with no press_cnt change; after release of rst a still-held key SHALL be debounced again as a new press.

Verification
REQ-026 keys=10'b0000001000 held, bcd_ready=1 -> bcd=3, bcd_valid high for exactly 1 cycle after edge 5, press_cnt=1; no second digit until keys=0 for 4 samples.
REQ-027 keys=10'b0000000001, bcd_ready=0 for 20 cycles then 1 -> bcd=0, bcd_valid held 20+ cycles, drops the cycle after the handshake, press_cnt=1.
REQ-028 keys=10'b0000100100 held 10 cycles -> err single-cycle pulse, bcd_valid never asserted, press_cnt unchanged.
REQ-029 keys toggling 10'b0000010000/0 every 2 cycles for 20 cycles, then stable 10'b1000000000 -> no acceptance during bounce, then exactly one digit bcd=9.
REQ-030 rst pulsed while bcd_valid=1 (bcd=7, no ready) -> next cycle all outputs 0; key still held -> bcd=7 re-presented after edge 5 post-reset.
REQ-031 256 accepted presses of keys=10'b0000000010 -> press_cnt wraps to 0, each bcd=1.
